// File: rtl/octal_req_arbiter_if.sv
// octal_req_arbiter_if
//   Handshake bundle between the requester bank / shared resource and the
//   arbiter.
//   master : requester side. It drives req and done and observes the grant.
//   slave  : arbiter side. It samples req and done and drives grant, code,
//            valid and timeout.
//   req[7:0]   level request lines, one per requester
//   done       resource finished with the current grant
//   grant[7:0] one-hot registered grant
//   code[2:0]  binary index of the granted requester
//   valid      a grant is active
//   timeout    one-cycle pulse when a grant was revoked by the hold limit
interface octal_req_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] code;
    logic       valid;
    logic       timeout;

    modport master (output req, done, input grant, code, valid, timeout);
    modport slave  (input req, done, output grant, code, valid, timeout);
endinterface

// File: rtl/octal_req_arbiter.sv
// octal_req_arbiter
//   Shares one downstream resource among eight requesters. In IDLE it picks
//   one winner from req. The default is the lowest asserted index. The grant
//   is held until done arrives or MAX_HOLD valid cycles have elapsed. A single
//   RELEASE cycle then separates it from the next arbitration.
//   Optional feature macro: ROUND_ROBIN_EN. When it is defined, the search
//   starts one past the previous winner and wraps 7->0.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : octal_req_arbiter_if.slave (req, done in; grant, code, valid,
//          timeout out, all outputs registered)
// Parameters
//   MAX_HOLD : maximum valid cycles without done (1 .. 2^CNT_W-1)
//   CNT_W    : hold counter width
module octal_req_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input logic               clk,
    input logic               rst,
    octal_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state, nxt_state;
    logic [7:0]       grant_q, nxt_grant;
    logic [2:0]       code_q, nxt_code;
    logic             valid_q, nxt_valid;
    logic             tmo_q, nxt_tmo;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [2:0]       win;

`ifdef ROUND_ROBIN_EN
    logic [2:0] rr_ptr, nxt_ptr;
    logic [2:0] rr_idx;
    logic       found;

    // The search starts at pointer+1. The first hit while walking upward with
    // 3-bit wrap wins. Reset leaves the pointer at 7, so the first search
    // starts at bit 0.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        rr_idx = '0;
        for (int off = 0; off < 8; off++) begin
            rr_idx = rr_ptr + 3'd1 + 3'(off);
            if (!found && bus.req[rr_idx]) begin
                win   = rr_idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority with bit 0 highest. Scanning downward lets the lowest
    // asserted index overwrite any higher index.
    always_comb begin
        win = '0;
        for (int i = 7; i >= 0; i--)
            if (bus.req[i]) win = 3'(i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= nxt_state;
            grant_q <= nxt_grant;
            code_q  <= nxt_code;
            valid_q <= nxt_valid;
            tmo_q   <= nxt_tmo;
            cnt     <= nxt_cnt;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= 3'd7;
        else     rr_ptr <= nxt_ptr;
    end
`endif

    always_comb begin
        nxt_state = state;
        nxt_grant = grant_q;
        nxt_code  = code_q;
        nxt_valid = valid_q;
        nxt_tmo   = 1'b0;
        nxt_cnt   = cnt;
`ifdef ROUND_ROBIN_EN
        nxt_ptr   = rr_ptr;
`endif
        case (state)
            IDLE: begin
                nxt_grant = '0;
                nxt_valid = 1'b0;
                if (|bus.req) begin
                    nxt_state = GRANT;
                    nxt_grant = 8'b1 << win;
                    nxt_code  = win;
                    nxt_valid = 1'b1;
                    nxt_cnt   = CNT_W'(1);
`ifdef ROUND_ROBIN_EN
                    nxt_ptr   = win;
`endif
                end
            end
            GRANT: begin
                // grant and code stay frozen. done wins over the hold limit.
                if (bus.done) begin
                    nxt_state = RELEASE;
                    nxt_grant = '0;
                    nxt_valid = 1'b0;
                end else if (cnt == CNT_W'(MAX_HOLD)) begin
                    nxt_state = RELEASE;
                    nxt_grant = '0;
                    nxt_valid = 1'b0;
                    nxt_tmo   = 1'b1;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                nxt_state = IDLE;
                nxt_grant = '0;
                nxt_valid = 1'b0;
            end
            default: begin
                nxt_state = IDLE;
                nxt_grant = '0;
                nxt_valid = 1'b0;
            end
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = tmo_q;

endmodule

// File: doc/octal_req_arbiter.md
# octal_req_arbiter

Sequential arbiter that shares one downstream resource among eight requesters. Each cycle it is idle, it picks one winner from `req[7:0]` using the team's 8-to-3 priority rule (bit 0 highest) or, optionally, rotating priority. It holds the grant until the resource signals `done` or a hold-timeout expires. It sits between the requester bank and the shared datapath and drives that datapath's select code directly.

## Interface
- `MAX_HOLD`, 15: maximum cycles a grant may stay valid without `done`. Legal range is 1 to 2^`CNT_W`-1.
- `CNT_W`, 4: width of the hold counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request lines, one per requester; level-sensitive.
- `done`  in  1  resource finished with the current grant; sampled only in GRANT.
- `grant`  out  8  one-hot grant, registered.
- `code`  out  3  binary index of the granted requester, registered; equals the position of the `grant` bit.
- `valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse: the previous grant was revoked by the hold limit.

## Operation
- FSM states: IDLE, GRANT, RELEASE. Encoding is free.
- Reset (async, immediate, any state): state=IDLE, `grant`=0, `code`=0, `valid`=0, `timeout`=0, hold counter=0, RR pointer=7.
- IDLE:
  - `req`==0: remain in IDLE; outputs stay 0.
  - Otherwise: select the winner and go to GRANT. On that edge, `grant`/`code` load the winner, `valid`=1, counter=1.
- GRANT:
  - `grant`/`code` are frozen. Changes on `req`, including the winner dropping its request, are ignored.
  - `done`=1: go to RELEASE, with `timeout`=0.
  - Else if counter==`MAX_HOLD`: go to RELEASE, with `timeout`=1.
  - Else: counter+1.
  - `done` takes precedence over timeout when both occur in the same cycle.
- RELEASE:
  - Lasts exactly one cycle: `valid`=0, `grant`=0, `code` holds its last value.
  - `timeout` is high only during this cycle, and only if the grant was revoked by the hold limit.
  - Next state is always IDLE.
- `done` in IDLE or RELEASE is ignored.
- Winner selection (default): lowest-index asserted `req` bit.
- The RR pointer is updated to the winner's `code` on every IDLE→GRANT transition, whether the grant later ends by `done` or by timeout. It is used only when `ROUND_ROBIN_EN` is defined.

## Timing
- Request-to-grant latency: `req` asserted in IDLE before edge k gives `valid`=1 after edge k (1 cycle).
- Grant duration: with `done` high in the n-th `valid` cycle, `valid` lasts n cycles. With no `done`, it lasts exactly `MAX_HOLD` cycles.
- Back-to-back grants are separated by 2 `valid`-low cycles (RELEASE, then IDLE).
- `MAX_HOLD`=1: every grant without same-cycle `done` lasts 1 cycle and raises `timeout`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - The search starts at (pointer+1) mod 8 and wraps upward through 7→0. The first asserted bit wins.
  - From reset (pointer=7), the first search starts at bit 0, so the first grant matches fixed priority.
- Not defined: fixed priority with bit 0 highest. The pointer logic is absent. Requester 7 can starve.

## Test plan
- Reset: assert `rst` mid-GRANT with `req`=8'hFF. All outputs go to 0 immediately, without waiting for a clock edge. After release with `req`=8'h00, `valid` stays 0.
- Fixed priority: `req`=8'b1010_0100 in IDLE. Next cycle `grant`=8'b0000_0100, `code`=3'd2, `valid`=1.
- Done handshake: same grant, `done`=1 in the 3rd `valid` cycle. `valid` is high 3 cycles, `timeout` stays 0, and the next grant appears 2 cycles after `valid` falls.
- Timeout: `MAX_HOLD`=15, `req`=8'h10, `done` held 0. `valid` is high for 15 cycles with `code`=4, then `timeout`=1 for exactly one cycle with `valid`=0. Also drive `done`=1 in the 15th cycle: `timeout` must stay 0.
- Rotation: `req`=8'hFF held, `done`=1 in each first `valid` cycle.
  - With `ROUND_ROBIN_EN`: codes 0,1,2,…,7,0.
  - Without the macro: code 0 every time.
- Wrap/skip with `ROUND_ROBIN_EN`: last grant code 6, then `req`=8'b0010_0001. The next grant is code 0, not 5.
